// File: rtl/axis_split_avg.sv
// AXI-Stream lane splitter with per-lane decimation by 2^n.
// Supports block-average and pick-last modes, a hold control and a result counter.
module axis_split_avg #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int NUM_CH           = 2,
   parameter int OUT_WIDTH        = 14
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic [3:0]                    cfg_log2dec,
   input  logic                          cfg_mode,
   input  logic                          hold,
   output logic [NUM_CH*OUT_WIDTH-1:0]   data_out,
   output logic                          data_valid,
   output logic [31:0]                   result_cnt
);

   localparam int LW = AXIS_TDATA_WIDTH / NUM_CH;
   localparam int AW = OUT_WIDTH + 15;

   logic [15:0] cnt;
   logic [3:0]  n_q;
   logic        mode_q;
   logic        beat;
   logic        first;
   logic [3:0]  n_eff;
   logic        mode_eff;
   logic        last;
   logic [NUM_CH*OUT_WIDTH-1:0] res;

   assign beat = s_axis_tvalid & s_axis_tready;

   // Config is sampled on the first beat of a group, latched for the rest.
   always_comb begin
      first    = (cnt == 16'd0);
      n_eff    = first ? cfg_log2dec : n_q;
      mode_eff = first ? cfg_mode : mode_q;
      last     = ({1'b0, cnt} + 17'd1) == (17'd1 << n_eff);
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      logic signed [OUT_WIDTH-1:0] samp;
      logic signed [AW-1:0]        ext;
      logic signed [AW-1:0]        sum;
      logic signed [AW-1:0]        shf;
      logic signed [AW-1:0]        acc;

      assign samp = s_axis_tdata[c*LW +: OUT_WIDTH];
      assign ext  = {{(AW-OUT_WIDTH){samp[OUT_WIDTH-1]}}, samp};
      assign sum  = first ? ext : acc + ext;
      assign shf  = sum >>> n_eff;
      assign res[c*OUT_WIDTH +: OUT_WIDTH] =
         mode_eff ? samp : shf[OUT_WIDTH-1:0];

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            acc <= '0;
         end else if (beat) begin
            acc <= sum;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_axis_tready <= 1'b0;
         cnt           <= '0;
         n_q           <= '0;
         mode_q        <= 1'b0;
      end else begin
         s_axis_tready <= 1'b1;
         if (beat) begin
            cnt <= last ? 16'd0 : cnt + 16'd1;
            if (first) begin
               n_q    <= cfg_log2dec;
               mode_q <= cfg_mode;
            end
         end
      end
   end

   // A completed group under hold is dropped; outputs keep their old value.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         result_cnt <= '0;
      end else begin
         data_valid <= 1'b0;
         if (beat && last && !hold) begin
            data_out   <= res;
            data_valid <= 1'b1;
            result_cnt <= result_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_axis_split_avg.sv
// Randomised and directed bench for axis_split_avg.
// A queue-based group model predicts every output cycle by cycle.
module tb_axis_split_avg;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] tdata = '0;
   logic        tvalid = 1'b0;
   logic        tready;
   logic [3:0]  log2dec = '0;
   logic        mode = 1'b0;
   logic        hold = 1'b0;
   logic [27:0] dout;
   logic        dvalid;
   logic [31:0] rcnt;

   int total = 0;
   int bad = 0;

   bit          m_ready;
   logic [31:0] grp[$];
   int          m_n;
   bit          m_mode;
   logic [27:0] e_out;
   bit          e_valid;
   logic [31:0] e_cnt;

   always #5 aclk = ~aclk;

   axis_split_avg #(
      .AXIS_TDATA_WIDTH(32),
      .NUM_CH(2),
      .OUT_WIDTH(14)
   ) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .s_axis_tdata(tdata),
      .s_axis_tvalid(tvalid),
      .s_axis_tready(tready),
      .cfg_log2dec(log2dec),
      .cfg_mode(mode),
      .hold(hold),
      .data_out(dout),
      .data_valid(dvalid),
      .result_cnt(rcnt)
   );

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int lane(logic [31:0] d, int c);
      logic [31:0] sh;
      logic [13:0] v;
      sh = d >> (c * 16);
      v  = sh[13:0];
      return int'($signed(v));
   endfunction

   function automatic logic [31:0] mk(int l0, int l1);
      logic [13:0] a;
      logic [13:0] b;
      a = 14'(l0);
      b = 14'(l1);
      return {2'b00, b, 2'b00, a};
   endfunction

   // Group of beats collected in a queue; result uses floor division.
   task automatic model_edge();
      bit     acc;
      int     r;
      longint s;
      longint d;
      acc = tvalid && m_ready;
      e_valid = 1'b0;
      if (acc) begin
         if (grp.size() == 0) begin
            m_n    = int'(log2dec);
            m_mode = mode;
         end
         grp.push_back(tdata);
         if (grp.size() == (1 << m_n)) begin
            if (!hold) begin
               for (int c = 0; c < 2; c++) begin
                  if (m_mode) begin
                     r = lane(grp[$], c);
                  end else begin
                     s = 0;
                     foreach (grp[i]) s += lane(grp[i], c);
                     d = longint'(1) << m_n;
                     r = int'(s / d);
                     if ((s % d) != 0 && s < 0) r--;
                  end
                  e_out[c*14 +: 14] = 14'(r);
               end
               e_valid = 1'b1;
               e_cnt++;
            end
            grp.delete();
         end
      end
      m_ready = 1'b1;
   endtask

   task automatic cyc();
      @(posedge aclk);
      model_edge();
      #1;
      check("valid", dvalid, e_valid);
      check("data", dout, e_out);
      check("cnt", rcnt, e_cnt);
      check("ready", tready, m_ready);
   endtask

   task automatic beat(logic [31:0] d, logic v);
      tdata  = d;
      tvalid = v;
      cyc();
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      #1;
      check("rst_valid", dvalid, 1'b0);
      check("rst_data", dout, 28'h0);
      check("rst_cnt", rcnt, 32'h0);
      check("rst_ready", tready, 1'b0);
      m_ready = 1'b0;
      grp.delete();
      e_out   = '0;
      e_valid = 1'b0;
      e_cnt   = '0;
      tvalid  = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
   endtask

   initial begin
      m_ready = 1'b0;
      e_out   = '0;
      e_valid = 1'b0;
      e_cnt   = '0;
      m_n     = 0;
      m_mode  = 1'b0;
      #2;
      do_reset();
      cyc();

      // pass-through
      beat(32'h1FFF_2001, 1'b1);
      check("pass_data", dout, 28'h7FFE001);
      check("pass_cnt", rcnt, 32'd1);
      beat(32'h0, 1'b0);

      // averaging, including a negative floor case
      log2dec = 4'd2;
      beat(mk(10, 0), 1'b1);
      beat(mk(11, 0), 1'b1);
      beat(mk(12, 0), 1'b1);
      beat(mk(14, 0), 1'b1);
      check("avg_pos", dout[13:0], 14'd11);
      beat(mk(-1, 0), 1'b1);
      beat(mk(-1, 0), 1'b1);
      beat(mk(-1, 0), 1'b1);
      beat(mk(-2, 0), 1'b1);
      check("avg_neg", dout[13:0], 14'h3FFE);
      beat(32'h0, 1'b0);

      // pick-last with gaps
      log2dec = 4'd3;
      mode    = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         beat(mk(i, -i), 1'b1);
         if (i == 8) begin
            check("pick_strobe", dvalid, 1'b1);
            check("pick_data", dout[13:0], 14'd8);
         end
         beat(32'hFFFF_FFFF, 1'b0);
      end

      // hold drops the second group
      do_reset();
      cyc();
      log2dec = 4'd1;
      mode    = 1'b0;
      beat(mk(4, 2), 1'b1);
      beat(mk(6, 2), 1'b1);
      beat(mk(100, 0), 1'b1);
      hold = 1'b1;
      beat(mk(200, 0), 1'b1);
      hold = 1'b0;
      check("hold_strobe", dvalid, 1'b0);
      check("hold_data", dout[13:0], 14'd5);
      beat(mk(1, 0), 1'b1);
      beat(mk(3, 0), 1'b1);
      check("hold_cnt", rcnt, 32'd2);

      // config change mid-group waits for the next group
      do_reset();
      cyc();
      log2dec = 4'd2;
      beat(mk(1, 0), 1'b1);
      log2dec = 4'd0;
      beat(mk(2, 0), 1'b1);
      beat(mk(3, 0), 1'b1);
      beat(mk(4, 0), 1'b1);
      check("cfg_strobe", dvalid, 1'b1);
      beat(mk(7, 0), 1'b1);
      check("cfg_next", dout[13:0], 14'd7);

      // reset mid-group discards the partial group
      log2dec = 4'd2;
      beat(mk(50, 0), 1'b1);
      beat(mk(50, 0), 1'b1);
      beat(mk(50, 0), 1'b1);
      do_reset();
      cyc();
      for (int i = 0; i < 4; i++) beat(mk(4, 4), 1'b1);
      check("rmid_data", dout[13:0], 14'd4);
      check("rmid_cnt", rcnt, 32'd1);

      // randomised traffic
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 15) == 0) log2dec = 4'($urandom_range(0, 4));
         if ($urandom_range(0, 15) == 0) mode = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 4) == 0);
         if ($urandom_range(0, 799) == 0) begin
            do_reset();
         end
         beat($urandom, $urandom_range(0, 9) < 7);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
